top_clk_gen: RTL and testbench
==============================

TOP_CLK_GEN -- requirements
Module: top_clk_gen

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000: frequency of clk_board in Hz.
REQ-002 Parameter OUT_HZ, default 1_843_200 (115200 baud x16 oversample): target frequency of clk_out_uart in Hz.
REQ-003 Port clk_board  input  1  board clock; sole clock, all logic on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset; 0 = asserted.
REQ-005 Port enable  input  1  run control, synchronous to clk_board, active-high.
REQ-006 Port clk_out_uart  output  1  generated UART clock, driven directly from a flip-flop.

Function
REQ-007 Fractional divider: internal accumulator acc, unsigned, width ACC_W = clog2(CLK_HZ + 2*OUT_HZ) + 1 bits; no overflow for any legal parameter set.
REQ-008 Rising edge with reset=1 and enable=1: sum = acc + 2*OUT_HZ; if sum >= CLK_HZ then acc <= sum - CLK_HZ and clk_out_uart toggles; else acc <= sum and clk_out_uart holds.
REQ-009 Long-run average frequency of clk_out_uart is exactly OUT_HZ. Each high or low phase lasts floor or ceil of CLK_HZ/(2*OUT_HZ) cycles, never any other length.
REQ-010 Equal-length phases (50% duty) when CLK_HZ is divisible by 2*OUT_HZ; otherwise phase lengths differ by at most one cycle.
REQ-011 Rising edge with reset=1 and enable=0: acc <= 0 and clk_out_uart <= 0. Restart after enable returns to 1 is cycle-identical to restart after reset release.
REQ-012 Edge on which enable rises: accumulation begins on that same edge (no extra latency). First toggle (low->high) occurs on the ceil(CLK_HZ/(2*OUT_HZ))-th consecutive enabled edge.
REQ-013 enable is a plain synchronous input: no synchronizer, no edge detection. Single-cycle enable=0 pulses take effect (clear) on that edge.
REQ-014 Parameter legality: OUT_HZ >= 1 and 2*OUT_HZ <= CLK_HZ; any violation is an elaboration-time error.
REQ-015 clk_out_uart is glitch-free: it changes only on clk_board rising edges or on reset assertion.
REQ-016 No combinational path from any input to clk_out_uart.

Reset
REQ-017 reset=0 asynchronously, without waiting for a clock edge: acc = 0, clk_out_uart = 0.
REQ-018 Reset asserted mid-period: output goes to 0 immediately and any partial phase is discarded.
REQ-019 Reset release: first rising edge with reset=1 is treated per REQ-008/REQ-011 per enable, with no additional wait states.
REQ-020 Reset has priority over enable.

Verification
REQ-021 CLK_HZ=8, OUT_HZ=1, enable=1 after reset release -> clk_out_uart rises on 4th edge, falls on 8th, period 8 cycles, 4 high / 4 low, repeating.
REQ-022 CLK_HZ=7, OUT_HZ=1, enable=1 -> toggles on edges 4, 7, 11, 14, 18, 21 (high 3, low 4 cycles); 7000 cycles yield exactly 1000 rising edges.
REQ-023 CLK_HZ=8, OUT_HZ=1, enable dropped for 1 cycle while output high -> output 0 on that edge; next rise exactly 4 enabled edges later.
REQ-024 Any parameters, reset driven 0 asynchronously between clock edges while output high -> clk_out_uart 0 before next edge; post-release sequence identical to REQ-021.
REQ-025 Defaults (100 MHz -> 1.8432 MHz): over 100_000_000 cycles, count 1_843_200 rising edges exactly; every phase is 27 or 28 cycles.
REQ-026 CLK_HZ=2, OUT_HZ=1 (boundary 2*OUT_HZ = CLK_HZ) -> output toggles every enabled edge; period 2 cycles.

Source files
------------

// File: rtl/top_clk_gen.sv
// Fractional clock divider: produces clk_out_uart at an average of OUT_HZ from clk_board
// by toggling a registered output whenever a phase accumulator wraps past CLK_HZ.
module top_clk_gen #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned OUT_HZ = 1_843_200
) (
  input  logic clk_board,
  input  logic reset,
  input  logic enable,
  output logic clk_out_uart
);

  localparam longint unsigned STEP64  = 64'(OUT_HZ) * 64'd2;
  localparam longint unsigned LIMIT64 = 64'(CLK_HZ);
  localparam int unsigned     ACC_W   = int'($clog2(LIMIT64 + STEP64)) + 1;

  localparam logic [ACC_W-1:0] STEP  = ACC_W'(STEP64);
  localparam logic [ACC_W-1:0] LIMIT = ACC_W'(LIMIT64);

  if (OUT_HZ == 0 || STEP64 > LIMIT64) begin : g_param_check
    $error("top_clk_gen: need OUT_HZ >= 1 and 2*OUT_HZ <= CLK_HZ");
  end

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum;
  logic             clk_q, clk_d;

  // acc stays below CLK_HZ, so acc + 2*OUT_HZ always fits in ACC_W bits
  always_comb begin
    sum   = acc_q + STEP;
    acc_d = sum;
    clk_d = clk_q;
    if (!enable) begin
      acc_d = '0;
      clk_d = 1'b0;
    end else if (sum >= LIMIT) begin
      acc_d = sum - LIMIT;
      clk_d = ~clk_q;
    end
  end

  always_ff @(posedge clk_board or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      clk_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      clk_q <= clk_d;
    end
  end

  assign clk_out_uart = clk_q;

endmodule

// File: tb/tb_top_clk_gen.sv
// Directed bench for top_clk_gen: four instances (8/1, 7/1, 2/1 and defaults) share
// reset and enable; expected edge patterns and counts are hand-derived constants.
module tb_top_clk_gen;

  logic clk_board = 1'b0;
  logic reset;
  logic enable;
  logic o8, o7, o2, od;
  logic [3:0] outs;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  int unsigned run_len [4];
  int unsigned min_ph  [4];
  int unsigned max_ph  [4];
  int unsigned rises   [4];
  logic        prev    [4];

  always #5 clk_board = ~clk_board;

  top_clk_gen #(.CLK_HZ(8), .OUT_HZ(1)) u8 (
    .clk_board(clk_board), .reset(reset), .enable(enable), .clk_out_uart(o8));
  top_clk_gen #(.CLK_HZ(7), .OUT_HZ(1)) u7 (
    .clk_board(clk_board), .reset(reset), .enable(enable), .clk_out_uart(o7));
  top_clk_gen #(.CLK_HZ(2), .OUT_HZ(1)) u2 (
    .clk_board(clk_board), .reset(reset), .enable(enable), .clk_out_uart(o2));
  top_clk_gen ud (
    .clk_board(clk_board), .reset(reset), .enable(enable), .clk_out_uart(od));

  assign outs = {od, o2, o7, o8};

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin
      run_len[i] = 0;
      min_ph[i]  = 32'hFFFF_FFFF;
      max_ph[i]  = 0;
      rises[i]   = 0;
      prev[i]    = 1'b0;
    end
  endtask

  // one clock edge, then sample 1 time unit later and update phase statistics
  task automatic tick();
    @(posedge clk_board);
    #1;
    for (int i = 0; i < 4; i++) begin
      run_len[i]++;
      if (outs[i] !== prev[i]) begin
        if (run_len[i] < min_ph[i]) min_ph[i] = run_len[i];
        if (run_len[i] > max_ph[i]) max_ph[i] = run_len[i];
        run_len[i] = 0;
        if (outs[i] === 1'b1) rises[i]++;
      end
      prev[i] = outs[i];
    end
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    enable = 1'b0;
    tick();
    tick();
    reset  = 1'b1;
    enable = 1'b1;
    clear_stats();
  endtask

  // samples the 16 edges after a (re)start; bit e holds the output after edge e
  task automatic check_pattern(input string tag);
    logic [16:1] v8, v7, v2, vd;
    for (int e = 1; e <= 16; e++) begin
      tick();
      v8[e] = o8;
      v7[e] = o7;
      v2[e] = o2;
      vd[e] = od;
    end
    check({tag, "_div8"}, v8, 16'h7878);
    check({tag, "_div7"}, v7, 16'h1C38);
    check({tag, "_div2"}, v2, 16'h5555);
    check({tag, "_dflt"}, vd, 16'h0000);
  endtask

  initial begin
    logic any_high;
    reset  = 1'b0;
    enable = 1'b0;
    clear_stats();
    #2;
    check("rst_async_div8", o8, 0);
    tick();
    tick();
    check("rst_div8", o8, 0);
    check("rst_div7", o7, 0);
    check("rst_div2", o2, 0);
    check("rst_dflt", od, 0);

    // first run after reset release
    reset  = 1'b1;
    enable = 1'b1;
    clear_stats();
    check_pattern("release");

    // long run: 7000 edges, then up to 15625 (one full default ratio period)
    do_reset();
    for (int c = 0; c < 7000; c++) tick();
    check("rises7000_div7", rises[1], 1000);
    check("rises7000_div8", rises[0], 875);
    check("rises7000_div2", rises[2], 3500);
    for (int c = 7000; c < 15625; c++) tick();
    check("rises15625_dflt", rises[3], 288);
    check("end_level_dflt", od, 0);
    check("min_phase_dflt", min_ph[3], 27);
    check("max_phase_dflt", max_ph[3], 28);
    check("min_phase_div7", min_ph[1], 3);
    check("max_phase_div7", max_ph[1], 4);
    check("min_phase_div8", min_ph[0], 4);
    check("max_phase_div8", max_ph[0], 4);
    check("min_phase_div2", min_ph[2], 1);
    check("max_phase_div2", max_ph[2], 1);

    // single-cycle enable drop while div8 output is high
    do_reset();
    for (int c = 0; c < 4; c++) tick();
    check("pre_drop_div8", o8, 1);
    enable = 1'b0;
    tick();
    check("drop_div8", o8, 0);
    check("drop_div7", o7, 0);
    check("drop_div2", o2, 0);
    enable = 1'b1;
    check_pattern("reenable");

    // asynchronous reset between edges while outputs are high
    do_reset();
    for (int c = 0; c < 5; c++) tick();
    check("pre_async_div8", o8, 1);
    check("pre_async_div7", o7, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_div8", o8, 0);
    check("async_div7", o7, 0);
    tick();
    check("rst_over_en_div2", o2, 0);
    check("rst_over_en_div8", o8, 0);
    reset = 1'b1;
    clear_stats();
    check_pattern("post_async");

    // enable held low: outputs stay idle even for the every-edge divider
    enable   = 1'b0;
    any_high = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (outs !== 4'b0000) any_high = 1'b1;
    end
    check("idle_disabled", any_high, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
